spec_mem_seq: RTL and testbench
===============================

Name: spec_mem_seq

Overview:
- Sequences the Sail specification's per-instruction memory accesses onto one OBI-style data port (req/gnt/rvalid), one transaction at a time.
- Accesses are a first granule plus an optional second granule for misaligned accesses.
- Returns the captured read data to the spec's fst/snd rdata inputs.
- Sits between the spec wrapper and the formal memory model. It raises done_o when every granule has completed, so the checker can compare spec results against the core.

Parameters:
- TimeoutCycles, 16, maximum cycles spent in any wait state before a timeout error (only with SPEC_MEM_SEQ_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  sample the spec request vector; honoured only when busy_o=0
- rd_i  in  1  spec mem_read
- rd_snd_i  in  1  spec mem_read_snd_gran
- rd_fst_addr_i / rd_snd_addr_i  in  32  read granule addresses
- wr_i  in  1  spec mem_write
- wr_snd_i  in  1  spec mem_write_snd_gran
- wr_fst_addr_i / wr_snd_addr_i  in  32  write granule addresses
- wr_fst_wdata_i / wr_snd_wdata_i  in  32  write data
- wr_fst_be_i / wr_snd_be_i  in  4  byte enables
- data_req_o  out  1  request
- data_we_o  out  1  write enable
- data_addr_o  out  32  word address (addr with [1:0] forced to 0)
- data_be_o  out  4  byte enables (4'hF for reads)
- data_wdata_o  out  32  write data
- data_gnt_i  in  1  grant
- data_rvalid_i  in  1  response valid
- data_rdata_i  in  32  response data
- data_err_i  in  1  bus error, qualified by rvalid
- fst_rdata_o / snd_rdata_o  out  32  captured read data
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  bus/timeout error for the completed sequence; valid with done_o
- proto_err_o  out  1  sticky protocol violation

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state IDLE.
  - All outputs 0; rdata registers 0; proto_err_o cleared.
  - Asserting reset mid-sequence abandons it with no done_o.
- States: IDLE, FST_REQ, FST_WAIT, SND_REQ, SND_WAIT, DONE.
- IDLE, start_i=1: latch all request inputs.
  - wr_i=1 and rd_i=1 together: set proto_err_o and go to DONE with err_o=1 (the core has no atomics).
  - Neither rd_i nor wr_i: go to DONE (done_o the next cycle, err_o=0).
  - Otherwise go to FST_REQ.
  - Clear fst_rdata_o and snd_rdata_o on every accepted start.
- FST_REQ / SND_REQ:
  - data_req_o=1; addr/we/be/wdata driven from the latched granule.
  - Request held stable until data_gnt_i.
  - On gnt, go to the matching WAIT state.
- FST_WAIT / SND_WAIT:
  - data_req_o=0. On data_rvalid_i, capture data_rdata_i into the granule's rdata register (reads only).
  - data_err_i=1: set the err flag and go to DONE, skipping the second granule.
  - Else from FST_WAIT: go to SND_REQ if the latched snd flag is set, else DONE.
  - From SND_WAIT: go to DONE.
- DONE: done_o=1 and err_o=err flag for exactly one cycle, then IDLE.
- start_i while busy_o=1: ignored; latched values are unchanged.
- Minimum latency, one granule, gnt in the request cycle, rvalid one cycle later: start at T -> req at T+1 -> rvalid at T+2 -> done_o at T+3.
- Two granules: +2 cycles minimum.
- Protocol violations (proto_err_o set, sticky until reset):
  - rvalid seen outside a WAIT state, including in the gnt cycle.
  - gnt seen while req=0.
- fst_rdata_o/snd_rdata_o hold their values until the next accepted start.
- Addresses are passed through unchanged apart from zeroing [1:0]; no arithmetic wrap.

Optional Feature:
- Macro: SPEC_MEM_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit saturating wait counter, cleared on every state change, increments in REQ/WAIT states.
  - Reaching TimeoutCycles forces DONE with err_o=1 and sets proto_err_o.
  - A late rvalid after the timeout counts as a protocol violation.
- Undefined: no counter; the sequencer waits indefinitely. The liveness property is left to the environment.

Decomposition:
- Shared package spec_mem_pkg:
  - enum spec_mem_state_e.
  - packed struct spec_mem_gran_t {addr, wdata, be, we}.
  - constant SpecMemBeRead = 4'hF.
- One sub-module, spec_mem_gran_mux: selects the latched fst/snd granule for the bus drive.
- The FSM stays in spec_mem_seq.

Test Plan:
- Aligned read:
  - Stimulus: rd_i=1, addr 0x1004, gnt immediate, rdata 0xDEADBEEF.
  - Response: one req with addr 0x1004 and be 4'hF; fst_rdata_o=0xDEADBEEF; done_o at T+3; err_o=0.
- Misaligned write:
  - Stimulus: wr_i=1, wr_snd_i=1, addrs 0x2002/0x2004, be 4'hC/4'h3, gnt delayed 3 cycles each.
  - Response: two ordered writes with addr 0x2000 then 0x2004; req stable while waiting; done_o once.
- First-granule error:
  - Stimulus: rd_i=1, rd_snd_i=1, data_err_i=1 on the first rvalid.
  - Response: no second req; done_o with err_o=1.
- Empty start:
  - Stimulus: start_i with rd_i=wr_i=0.
  - Response: no req; done_o next cycle. A start_i during a busy sequence is ignored.
- Reset mid-operation:
  - Stimulus: rst_ni low during SND_WAIT.
  - Response: all outputs 0 immediately; no done_o; a subsequent read works normally.
- Violations / timeout:
  - rvalid in IDLE sets proto_err_o sticky.
  - With SPEC_MEM_SEQ_TIMEOUT_EN and gnt withheld for 16 cycles: done_o with err_o=1.

Source files
------------

// File: rtl/spec_mem_pkg.sv
// Shared types for the spec memory sequencer: FSM states, granule descriptor, read byte-enable constant.
package spec_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FST_REQ,
        ST_FST_WAIT,
        ST_SND_REQ,
        ST_SND_WAIT,
        ST_DONE
    } spec_mem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } spec_mem_gran_t;

    localparam logic [3:0] SpecMemBeRead = 4'hF;

    function automatic spec_mem_gran_t gran_pack(input logic [31:0] addr,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  be,
                                                 input logic        we);
        spec_mem_gran_t g;
        g.addr  = addr;
        g.wdata = wdata;
        g.be    = be;
        g.we    = we;
        return g;
    endfunction

endpackage

// File: rtl/spec_mem_gran_mux.sv
// Purpose: picks the latched first/second granule for the data bus; word-aligns the address.
// Latency: combinational.
// Backpressure: none; drives all-zero whenever no request is active.
module spec_mem_gran_mux
    import spec_mem_pkg::*;
(
    input  spec_mem_gran_t fst_i,
    input  spec_mem_gran_t snd_i,
    input  logic           sel_snd_i,
    input  logic           en_i,
    output spec_mem_gran_t gran_o
);

    always_comb begin
        gran_o = '0;
        if (en_i) begin
            gran_o           = sel_snd_i ? snd_i : fst_i;
            gran_o.addr[1:0] = 2'b00;
        end
    end

endmodule

// File: rtl/spec_mem_seq.sv
// Purpose: serialises a spec instruction's one/two memory granules onto an OBI-style port, returns read data.
// Latency: start->done 3 cycles for one granule with immediate gnt/rvalid, +2 per extra granule.
// Backpressure: req held stable until gnt; start ignored while busy. SPEC_MEM_SEQ_TIMEOUT_EN bounds waits.
module spec_mem_seq
    import spec_mem_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        rd_i,
    input  logic        rd_snd_i,
    input  logic [31:0] rd_fst_addr_i,
    input  logic [31:0] rd_snd_addr_i,
    input  logic        wr_i,
    input  logic        wr_snd_i,
    input  logic [31:0] wr_fst_addr_i,
    input  logic [31:0] wr_snd_addr_i,
    input  logic [31:0] wr_fst_wdata_i,
    input  logic [31:0] wr_snd_wdata_i,
    input  logic [3:0]  wr_fst_be_i,
    input  logic [3:0]  wr_snd_be_i,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] fst_rdata_o,
    output logic [31:0] snd_rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        proto_err_o
);

    spec_mem_state_e state_q, state_d;
    spec_mem_gran_t  fst_q, fst_d, snd_q, snd_d, bus;
    logic            snd_en_q, snd_en_d;
    logic            err_q, err_d;
    logic            proto_q, proto_d;
    logic [31:0]     fst_rdata_q, fst_rdata_d, snd_rdata_q, snd_rdata_d;
    logic            req, in_wait;

`ifdef SPEC_MEM_SEQ_TIMEOUT_EN
    logic [7:0]      wait_cnt_q, wait_cnt_d;
`else
    logic            unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles != 0);
`endif

    assign req     = (state_q == ST_FST_REQ)  || (state_q == ST_SND_REQ);
    assign in_wait = (state_q == ST_FST_WAIT) || (state_q == ST_SND_WAIT);

    always_comb begin
        state_d     = state_q;
        fst_d       = fst_q;
        snd_d       = snd_q;
        snd_en_d    = snd_en_q;
        err_d       = err_q;
        proto_d     = proto_q;
        fst_rdata_d = fst_rdata_q;
        snd_rdata_d = snd_rdata_q;

        // A response outside a wait state, or a grant with nothing requested, is a bus protocol bug.
        if ((data_rvalid_i && !in_wait) || (data_gnt_i && !req)) begin
            proto_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    fst_d       = wr_i ? gran_pack(wr_fst_addr_i, wr_fst_wdata_i, wr_fst_be_i, 1'b1)
                                       : gran_pack(rd_fst_addr_i, 32'h0, SpecMemBeRead, 1'b0);
                    snd_d       = wr_i ? gran_pack(wr_snd_addr_i, wr_snd_wdata_i, wr_snd_be_i, 1'b1)
                                       : gran_pack(rd_snd_addr_i, 32'h0, SpecMemBeRead, 1'b0);
                    snd_en_d    = wr_i ? wr_snd_i : rd_snd_i;
                    err_d       = 1'b0;
                    fst_rdata_d = '0;
                    snd_rdata_d = '0;
                    if (rd_i && wr_i) begin
                        // No atomics in the core: read+write together is reported, never issued.
                        proto_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (rd_i || wr_i) begin
                        state_d = ST_FST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FST_REQ: if (data_gnt_i) state_d = ST_FST_WAIT;
            ST_FST_WAIT: begin
                if (data_rvalid_i) begin
                    if (!fst_q.we) fst_rdata_d = data_rdata_i;
                    if (data_err_i) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = snd_en_q ? ST_SND_REQ : ST_DONE;
                    end
                end
            end
            ST_SND_REQ: if (data_gnt_i) state_d = ST_SND_WAIT;
            ST_SND_WAIT: begin
                if (data_rvalid_i) begin
                    if (!snd_q.we) snd_rdata_d = data_rdata_i;
                    if (data_err_i) err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef SPEC_MEM_SEQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (req || in_wait) begin
            if (wait_cnt_q >= 8'(TimeoutCycles - 1)) begin
                state_d    = ST_DONE;
                err_d      = 1'b1;
                proto_d    = 1'b1;
                wait_cnt_d = '0;
            end else if (wait_cnt_q != 8'hFF) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            fst_q       <= '0;
            snd_q       <= '0;
            snd_en_q    <= 1'b0;
            err_q       <= 1'b0;
            proto_q     <= 1'b0;
            fst_rdata_q <= '0;
            snd_rdata_q <= '0;
`ifdef SPEC_MEM_SEQ_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fst_q       <= fst_d;
            snd_q       <= snd_d;
            snd_en_q    <= snd_en_d;
            err_q       <= err_d;
            proto_q     <= proto_d;
            fst_rdata_q <= fst_rdata_d;
            snd_rdata_q <= snd_rdata_d;
`ifdef SPEC_MEM_SEQ_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    spec_mem_gran_mux u_gran_mux (
        .fst_i     (fst_q),
        .snd_i     (snd_q),
        .sel_snd_i (state_q == ST_SND_REQ),
        .en_i      (req),
        .gran_o    (bus)
    );

    assign data_req_o   = req;
    assign data_we_o    = bus.we;
    assign data_addr_o  = bus.addr;
    assign data_be_o    = bus.be;
    assign data_wdata_o = bus.wdata;
    assign fst_rdata_o  = fst_rdata_q;
    assign snd_rdata_o  = snd_rdata_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_DONE) && err_q;
    assign proto_err_o  = proto_q;

endmodule

// File: tb/tb_spec_mem_seq.sv
// Directed + randomized bench for spec_mem_seq with a granule-list reference model and a bus responder.
module tb_spec_mem_seq;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        rd_i = 1'b0, rd_snd_i = 1'b0, wr_i = 1'b0, wr_snd_i = 1'b0;
    logic [31:0] rd_fst_addr_i = '0, rd_snd_addr_i = '0, wr_fst_addr_i = '0, wr_snd_addr_i = '0;
    logic [31:0] wr_fst_wdata_i = '0, wr_snd_wdata_i = '0;
    logic [3:0]  wr_fst_be_i = '0, wr_snd_be_i = '0;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic [31:0] fst_rdata_o, snd_rdata_o;
    logic        busy_o, done_o, err_o, proto_err_o;

    int total = 0;
    int bad   = 0;
    bit exp_proto = 1'b0;
    logic [31:0] rsp_data [2];
    bit          rsp_err  [2];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } req_t;

    always #5 clk_i = ~clk_i;

    spec_mem_seq #(.TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .rd_i(rd_i), .rd_snd_i(rd_snd_i), .rd_fst_addr_i(rd_fst_addr_i), .rd_snd_addr_i(rd_snd_addr_i),
        .wr_i(wr_i), .wr_snd_i(wr_snd_i), .wr_fst_addr_i(wr_fst_addr_i), .wr_snd_addr_i(wr_snd_addr_i),
        .wr_fst_wdata_i(wr_fst_wdata_i), .wr_snd_wdata_i(wr_snd_wdata_i),
        .wr_fst_be_i(wr_fst_be_i), .wr_snd_be_i(wr_snd_be_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_err_i(data_err_i),
        .fst_rdata_o(fst_rdata_o), .snd_rdata_o(snd_rdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .proto_err_o(proto_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_req_inputs();
        rd_i = 1'b0; rd_snd_i = 1'b0; wr_i = 1'b0; wr_snd_i = 1'b0;
    endtask

    task automatic scramble_inputs();
        rd_i = 1'($urandom); rd_snd_i = 1'($urandom); wr_i = 1'($urandom); wr_snd_i = 1'($urandom);
        rd_fst_addr_i = $urandom; rd_snd_addr_i = $urandom;
        wr_fst_addr_i = $urandom; wr_snd_addr_i = $urandom;
        wr_fst_wdata_i = $urandom; wr_snd_wdata_i = $urandom;
        wr_fst_be_i = 4'($urandom); wr_snd_be_i = 4'($urandom);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0; start_i = 1'b0; clear_req_inputs();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
        #1;
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_proto", 32'(proto_err_o), 32'd0);
        chk("rst_req",   32'(data_req_o), 32'd0);
        chk("rst_addr",  data_addr_o, 32'd0);
        chk("rst_fst",   fst_rdata_o, 32'd0);
        chk("rst_snd",   snd_rdata_o, 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();
        exp_proto = 1'b0;
    endtask

    // Runs one sequence from the currently driven request inputs. gdly = cycles req waits for gnt,
    // rdly = cycles from gnt to rvalid (>=1), errN = bus error on granule N's response.
    task automatic run_txn(input int gdly, input int rdly, input bit err0, input bit err1,
                           input bit poke, input bit rst_mid, input bit to_case);
        req_t exp_q[$];
        req_t cur, held;
        bit both, exp_err, in_req, stable, rst_hit, got_err;
        int issued, exp_done, n_obs, n_done, done_cyc, wcnt, rv_cnt, n_rsp;
        logic [31:0] exp_fst, exp_snd;

        both = rd_i && wr_i;
        if (!both && rd_i) begin
            exp_q.push_back('{addr: rd_fst_addr_i & 32'hFFFF_FFFC, wdata: 32'h0, be: 4'hF, we: 1'b0});
            if (rd_snd_i)
                exp_q.push_back('{addr: rd_snd_addr_i & 32'hFFFF_FFFC, wdata: 32'h0, be: 4'hF, we: 1'b0});
        end else if (!both && wr_i) begin
            exp_q.push_back('{addr: wr_fst_addr_i & 32'hFFFF_FFFC, wdata: wr_fst_wdata_i, be: wr_fst_be_i, we: 1'b1});
            if (wr_snd_i)
                exp_q.push_back('{addr: wr_snd_addr_i & 32'hFFFF_FFFC, wdata: wr_snd_wdata_i, be: wr_snd_be_i, we: 1'b1});
        end
        issued   = (to_case || (err0 && exp_q.size() > 0)) ? ((exp_q.size() > 0) ? 1 : 0) : exp_q.size();
        exp_err  = both || to_case || (issued >= 1 && err0) || (issued == 2 && err1);
        exp_done = to_case ? 1 + TO : 1 + issued * (gdly + rdly + 1);
        if (both || to_case) exp_proto = 1'b1;
        rsp_data[0] = $urandom; rsp_data[1] = $urandom;
        rsp_err[0]  = err0;     rsp_err[1]  = err1;
        exp_fst = (!to_case && issued >= 1 && !exp_q[0].we) ? rsp_data[0] : 32'h0;
        exp_snd = (issued == 2 && !exp_q[1].we) ? rsp_data[1] : 32'h0;

        n_obs = 0; n_done = 0; done_cyc = 0; wcnt = 0; rv_cnt = 0; n_rsp = 0;
        in_req = 0; stable = 1; rst_hit = 0; got_err = 0; held = '0;
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            step();
            start_i = poke && (cyc == 1);
            if (cyc == 1) scramble_inputs();
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
            if (rst_mid && n_obs == 2 && !data_req_o) begin
                rst_ni = 1'b0;
                start_i = 1'b0;
                #1;
                chk("midrst_busy",  32'(busy_o), 32'd0);
                chk("midrst_done",  32'(done_o), 32'd0);
                chk("midrst_req",   32'(data_req_o), 32'd0);
                chk("midrst_fst",   fst_rdata_o, 32'd0);
                chk("midrst_proto", 32'(proto_err_o), 32'd0);
                chk("midrst_no_done_before", 32'(n_done), 32'd0);
                rst_hit = 1; exp_proto = 1'b0;
                step();
                rst_ni = 1'b1;
                break;
            end
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0 && n_rsp < 2) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rsp_data[n_rsp];
                    data_err_i    = rsp_err[n_rsp];
                    n_rsp++;
                end
            end
            if (data_req_o) begin
                cur = '{addr: data_addr_o, wdata: data_wdata_o, be: data_be_o, we: data_we_o};
                if (!in_req) begin
                    in_req = 1; wcnt = 0; held = cur; stable = 1;
                    if (n_obs < exp_q.size()) begin
                        chk("req_addr", cur.addr, exp_q[n_obs].addr);
                        chk("req_be",   32'(cur.be), 32'(exp_q[n_obs].be));
                        chk("req_we",   32'(cur.we), 32'(exp_q[n_obs].we));
                        if (exp_q[n_obs].we) chk("req_wdata", cur.wdata, exp_q[n_obs].wdata);
                    end else begin
                        chk("extra_req", 32'(n_obs + 1), 32'(exp_q.size()));
                    end
                    n_obs++;
                end else if (cur != held) begin
                    stable = 0;
                end
                if (wcnt == gdly) begin
                    data_gnt_i = 1'b1; in_req = 0; rv_cnt = rdly;
                    if (gdly > 0) chk("req_stable", 32'(stable), 32'd1);
                end else begin
                    wcnt++;
                end
            end
            if (done_o) begin
                n_done++;
                if (n_done == 1) begin done_cyc = cyc; got_err = err_o; end
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) break;
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
        clear_req_inputs();

        if (rst_mid) begin
            chk("midrst_hit", 32'(rst_hit), 32'd1);
        end else if (done_cyc == 0) begin
            chk("done_seen", 32'd0, 32'd1);
        end else begin
            chk("done_cycle", 32'(done_cyc), 32'(exp_done));
            chk("done_err",   32'(got_err), 32'(exp_err));
            chk("done_once",  32'(n_done), 32'd1);
            chk("idle_after", 32'(busy_o), 32'd0);
            chk("req_count",  32'(n_obs), 32'(issued));
            chk("fst_rdata",  fst_rdata_o, exp_fst);
            chk("snd_rdata",  snd_rdata_o, exp_snd);
            chk("proto_err",  32'(proto_err_o), 32'(exp_proto));
        end
    endtask

    initial begin
        apply_reset();

        // aligned read, minimum latency
        rd_i = 1'b1; rd_fst_addr_i = 32'h0000_1004; rd_snd_i = 1'b0;
        run_txn(0, 1, 0, 0, 0, 0, 0);

        // misaligned write, grant delayed 3 cycles per granule
        wr_i = 1'b1; wr_snd_i = 1'b1;
        wr_fst_addr_i = 32'h0000_2002; wr_snd_addr_i = 32'h0000_2004;
        wr_fst_be_i = 4'hC; wr_snd_be_i = 4'h3;
        wr_fst_wdata_i = 32'hA5A5_0000; wr_snd_wdata_i = 32'h0000_5A5A;
        run_txn(3, 2, 0, 0, 0, 0, 0);

        // error on the first granule suppresses the second
        rd_i = 1'b1; rd_snd_i = 1'b1; rd_fst_addr_i = 32'h0000_3FFE; rd_snd_addr_i = 32'h0000_4000;
        run_txn(1, 1, 1, 0, 0, 0, 0);

        // empty start, with a start pulse during the busy cycle
        clear_req_inputs();
        run_txn(0, 1, 0, 0, 1, 0, 0);

        // rvalid in IDLE is a sticky violation
        data_rvalid_i = 1'b1;
        step();
        data_rvalid_i = 1'b0;
        step();
        exp_proto = 1'b1;
        chk("rvalid_idle_proto", 32'(proto_err_o), 32'd1);
        rd_i = 1'b1; rd_fst_addr_i = 32'h0000_1004;
        run_txn(0, 1, 0, 0, 0, 0, 0);

        // reset while waiting on the second granule, then a normal read
        rd_i = 1'b1; rd_snd_i = 1'b1; rd_fst_addr_i = 32'h0000_5002; rd_snd_addr_i = 32'h0000_5004;
        run_txn(0, 4, 0, 0, 0, 1, 0);
        rd_i = 1'b1; rd_fst_addr_i = 32'h0000_6008;
        run_txn(0, 1, 0, 0, 0, 0, 0);

        // grant with no request is a violation
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        step();
        chk("gnt_idle_proto", 32'(proto_err_o), 32'd1);

        apply_reset();
        for (int n = 0; n < 40; n++) begin
            int kind;
            scramble_inputs();
            kind = $urandom_range(0, 7);
            rd_i = (kind >= 1 && kind <= 3) || kind == 7;
            wr_i = (kind >= 4);
            run_txn($urandom_range(0, 3), $urandom_range(1, 3), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0), 1'($urandom), 0, 0);
        end

`ifdef SPEC_MEM_SEQ_TIMEOUT_EN
        apply_reset();
        rd_i = 1'b1; rd_snd_i = 1'b0; rd_fst_addr_i = 32'h0000_7000;
        run_txn(1000, 1, 0, 0, 0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
